gg_nal_start_detect: RTL and testbench

- Sits directly downstream of the emulation-prevention remover in the bitstream input path. Consumes 16-byte big-endian words and per-byte removal flags.
- Detects 00 00 01 start codes, including ones that straddle word boundaries, and ignores any candidate containing a flagged byte.
- Marks start-code and NAL-header byte lanes and captures NAL header fields.
- Passes data through with one register stage and full valid/ready backpressure.

---
 rtl/gg_nal_start_detect.sv | 143 ++++++++++++++
 tb/tb_gg_nal_start_detect.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/gg_nal_start_detect.sv
// NAL start-code detector: scans 16-byte big-endian words (plus two carried bytes) for
// unprotected 00 00 01 sequences, marks start-code and header lanes, and registers the beat.
module gg_nal_start_detect #(
  parameter int WIDTH      = 128,
  parameter int BYTE_WIDTH = WIDTH / 8,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH-1:0]      iport,
  input  logic [BYTE_WIDTH-1:0] iflag,
  input  logic                  iport_valid,
  output logic                  iport_ready,
  output logic [WIDTH-1:0]      oport,
  output logic [BYTE_WIDTH-1:0] oflag,
  output logic [BYTE_WIDTH-1:0] sc_mask,
  output logic [BYTE_WIDTH-1:0] hdr_mask,
  output logic                  oport_valid,
  input  logic                  oport_ready,
  output logic                  nal_valid,
  output logic [1:0]            nal_ref_idc,
  output logic [4:0]            nal_unit_type,
  output logic                  nal_fzb_err,
  output logic [CNT_W-1:0]      nal_count
);

  localparam int WIN_B = BYTE_WIDTH + 2;

  function automatic logic [4:0] popcount(input logic [BYTE_WIDTH-1:0] m);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < BYTE_WIDTH; i++) n = n + {4'd0, m[i]};
    return n;
  endfunction

  logic                  vld_p1;
  logic [WIDTH-1:0]      data_p1;
  logic [BYTE_WIDTH-1:0] flag_p1;
  logic [BYTE_WIDTH-1:0] sc_p1;
  logic [BYTE_WIDTH-1:0] hdr_p1;
  logic                  nal_vld_p1;
  logic [1:0]            ref_idc_p1;
  logic [4:0]            unit_type_p1;
  logic                  fzb_p1;
  logic [CNT_W-1:0]      count_p1;

  // Bytes carried from the previous accepted beat (lanes 1 and 0), with their flags.
  logic [7:0]            c1_byte, c0_byte;
  logic                  c1_flag, c0_flag;
  logic                  hdr_pend;

  logic                  accept;
  logic [8*WIN_B-1:0]    win_data_p0;
  logic [WIN_B-1:0]      win_flag_p0;
  logic [BYTE_WIDTH-1:0] sc_p0;
  logic [BYTE_WIDTH-1:0] hdr_p0;
  logic [7:0]            hdr_byte_p0;
  logic                  fzb_p0;

  assign iport_ready = ~vld_p1 | oport_ready;
  assign accept      = iport_valid & iport_ready;

  assign win_data_p0 = {c1_byte, c0_byte, iport};
  assign win_flag_p0 = {c1_flag, c0_flag, iflag};

  // Stage p0: window scan, header selection
  always_comb begin
    sc_p0 = '0;
    for (int i = 0; i < BYTE_WIDTH; i++) begin
      sc_p0[i] = (win_data_p0[8*i +: 8] == 8'h01) &&
                 (win_data_p0[8*(i+1) +: 8] == 8'h00) &&
                 (win_data_p0[8*(i+2) +: 8] == 8'h00) &&
                 (win_flag_p0[i +: 3] == 3'b000);
    end
  end

  assign hdr_p0 = {hdr_pend, sc_p0[BYTE_WIDTH-1:1]};

  // Scanning from lane 15 down leaves the last header byte in stream order selected.
  always_comb begin
    hdr_byte_p0 = 8'h00;
    fzb_p0      = 1'b0;
    for (int i = BYTE_WIDTH - 1; i >= 0; i--) begin
      if (hdr_p0[i]) begin
        hdr_byte_p0 = iport[8*i +: 8];
        fzb_p0      = fzb_p0 | iport[8*i+7];
      end
    end
  end

  // Stage p1: output register and carry state
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_p1       <= 1'b0;
      data_p1      <= '0;
      flag_p1      <= '0;
      sc_p1        <= '0;
      hdr_p1       <= '0;
      nal_vld_p1   <= 1'b0;
      ref_idc_p1   <= '0;
      unit_type_p1 <= '0;
      fzb_p1       <= 1'b0;
      count_p1     <= '0;
      c1_byte      <= 8'hFF;
      c0_byte      <= 8'hFF;
      c1_flag      <= 1'b0;
      c0_flag      <= 1'b0;
      hdr_pend     <= 1'b0;
    end else if (accept) begin
      vld_p1     <= 1'b1;
      data_p1    <= iport;
      flag_p1    <= iflag;
      sc_p1      <= sc_p0;
      hdr_p1     <= hdr_p0;
      nal_vld_p1 <= |hdr_p0;
      fzb_p1     <= fzb_p0;
      if (|hdr_p0) begin
        ref_idc_p1   <= hdr_byte_p0[6:5];
        unit_type_p1 <= hdr_byte_p0[4:0];
      end
      count_p1 <= count_p1 + CNT_W'(popcount(sc_p0));
      c1_byte  <= iport[15:8];
      c0_byte  <= iport[7:0];
      c1_flag  <= iflag[1];
      c0_flag  <= iflag[0];
      hdr_pend <= sc_p0[0];
    end else if (oport_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign oport_valid   = vld_p1;
  assign oport         = data_p1;
  assign oflag         = flag_p1;
  assign sc_mask       = sc_p1;
  assign hdr_mask      = hdr_p1;
  assign nal_valid     = nal_vld_p1 & vld_p1;
  assign nal_ref_idc   = ref_idc_p1;
  assign nal_unit_type = unit_type_p1;
  assign nal_fzb_err   = fzb_p1;
  assign nal_count     = count_p1;

endmodule

// File: tb/tb_gg_nal_start_detect.sv
// Directed bench for gg_nal_start_detect: a table of consecutive beats with hand-computed
// masks/fields, followed by backpressure and mid-stream reset sequences.
module tb_gg_nal_start_detect;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] iport;
  logic [15:0]  iflag;
  logic         iport_valid;
  logic         iport_ready;
  logic [127:0] oport;
  logic [15:0]  oflag;
  logic [15:0]  sc_mask;
  logic [15:0]  hdr_mask;
  logic         oport_valid;
  logic         oport_ready;
  logic         nal_valid;
  logic [1:0]   nal_ref_idc;
  logic [4:0]   nal_unit_type;
  logic         nal_fzb_err;
  logic [15:0]  nal_count;

  gg_nal_start_detect #(.WIDTH(128), .BYTE_WIDTH(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .iport(iport), .iflag(iflag), .iport_valid(iport_valid), .iport_ready(iport_ready),
    .oport(oport), .oflag(oflag), .sc_mask(sc_mask), .hdr_mask(hdr_mask),
    .oport_valid(oport_valid), .oport_ready(oport_ready),
    .nal_valid(nal_valid), .nal_ref_idc(nal_ref_idc), .nal_unit_type(nal_unit_type),
    .nal_fzb_err(nal_fzb_err), .nal_count(nal_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  flag;
    logic [15:0]  sc;
    logic [15:0]  hdr;
    logic         nv;
    logic [4:0]   typ;
    logic [1:0]   ref_idc;
    logic         fzb;
    logic [15:0]  cnt;
  } vec_t;

  localparam int NV = 15;
  vec_t vec [NV];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
  endtask

  task automatic chk_beat(input string tag, input vec_t v);
    chk({tag, " oport_valid"}, {127'd0, oport_valid}, 128'd1);
    chk({tag, " oport"}, oport, v.data);
    chk({tag, " oflag"}, {112'd0, oflag}, {112'd0, v.flag});
    chk({tag, " sc_mask"}, {112'd0, sc_mask}, {112'd0, v.sc});
    chk({tag, " hdr_mask"}, {112'd0, hdr_mask}, {112'd0, v.hdr});
    chk({tag, " nal_valid"}, {127'd0, nal_valid}, {127'd0, v.nv});
    chk({tag, " nal_unit_type"}, {123'd0, nal_unit_type}, {123'd0, v.typ});
    chk({tag, " nal_ref_idc"}, {126'd0, nal_ref_idc}, {126'd0, v.ref_idc});
    chk({tag, " nal_fzb_err"}, {127'd0, nal_fzb_err}, {127'd0, v.fzb});
    chk({tag, " nal_count"}, {112'd0, nal_count}, {112'd0, v.cnt});
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [127:0] d, input logic [15:0] f, input logic [15:0] sc,
                              input logic [15:0] hdr, input logic nv, input logic [4:0] typ,
                              input logic [1:0] r, input logic fzb, input logic [15:0] cnt);
    vec_t v;
    v.data = d; v.flag = f; v.sc = sc; v.hdr = hdr; v.nv = nv;
    v.typ = typ; v.ref_idc = r; v.fzb = fzb; v.cnt = cnt;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  x [4];
    vec_t  y;
    string s;

    // Consecutive beats; carry bytes flow from one row to the next.
    vec[0]  = mk(128'h00000165_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0000, 16'h2000, 16'h1000, 1, 5'd5,  2'd3, 0, 16'd1);
    vec[1]  = mk(128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAA0000, 16'h0000, 16'h0000, 16'h0000, 0, 5'd5,  2'd3, 0, 16'd1);
    vec[2]  = mk(128'h0167AAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0000, 16'h8000, 16'h4000, 1, 5'd7,  2'd3, 0, 16'd2);
    vec[3]  = mk(128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAA00, 16'h0000, 16'h0000, 16'h0000, 0, 5'd7,  2'd3, 0, 16'd2);
    vec[4]  = mk(128'h000168AA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0000, 16'h4000, 16'h2000, 1, 5'd8,  2'd3, 0, 16'd3);
    vec[5]  = mk(128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AA000001, 16'h0000, 16'h0001, 16'h0000, 0, 5'd8,  2'd3, 0, 16'd4);
    vec[6]  = mk(128'h41AAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0000, 16'h0000, 16'h8000, 1, 5'd1,  2'd2, 0, 16'd4);
    vec[7]  = mk(128'h00000165_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h2000, 16'h0000, 16'h0000, 0, 5'd1,  2'd2, 0, 16'd4);
    vec[8]  = mk(128'h00000165_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h8000, 16'h0000, 16'h0000, 0, 5'd1,  2'd2, 0, 16'd4);
    vec[9]  = mk(128'h00000165_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h4000, 16'h0000, 16'h0000, 0, 5'd1,  2'd2, 0, 16'd4);
    vec[10] = mk(128'h00000165_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0000, 16'h2000, 16'h1000, 1, 5'd5,  2'd3, 0, 16'd5);
    vec[11] = mk(128'h00000100_000142AA_AAAAAAAA_AAAAAAAA, 16'h0000, 16'h2400, 16'h1200, 1, 5'd2,  2'd2, 0, 16'd7);
    vec[12] = mk(128'h00000001_4EAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0000, 16'h1000, 16'h0800, 1, 5'd14, 2'd2, 0, 16'd8);
    vec[13] = mk(128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAA0000, 16'h0001, 16'h0000, 16'h0000, 0, 5'd14, 2'd2, 0, 16'd8);
    vec[14] = mk(128'h0167AAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0000, 16'h0000, 16'h0000, 0, 5'd14, 2'd2, 0, 16'd8);

    reset = 1'b1; iport = '0; iflag = '0; iport_valid = 1'b0; oport_ready = 1'b1;
    step(); step();
    chk("rst oport_valid", {127'd0, oport_valid}, 128'd0);
    chk("rst oport", oport, 128'd0);
    chk("rst sc_mask", {112'd0, sc_mask}, 128'd0);
    chk("rst nal_count", {112'd0, nal_count}, 128'd0);
    chk("rst nal_unit_type", {123'd0, nal_unit_type}, 128'd0);
    reset = 1'b0;
    step();

    // Table stream at full rate
    for (int i = 0; i < NV; i++) begin
      iport = vec[i].data; iflag = vec[i].flag; iport_valid = 1'b1;
      #1;
      chk($sformatf("v%0d iport_ready", i), {127'd0, iport_ready}, 128'd1);
      if (i == 0) chk("v0 pre-edge oport_valid", {127'd0, oport_valid}, 128'd0);
      step();
      chk_beat($sformatf("v%0d", i), vec[i]);
    end
    iport_valid = 1'b0;
    step();
    chk("drain oport_valid", {127'd0, oport_valid}, 128'd0);
    chk("drain nal_count", {112'd0, nal_count}, 128'd8);

    // Backpressure: first beat stalls 5 cycles, then three more at one per cycle
    reset = 1'b1; step(); reset = 1'b0;
    x[0] = mk(128'h00000109_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0000, 16'h2000, 16'h1000, 1, 5'd9,  2'd0, 0, 16'd1);
    x[1] = mk(128'hAAAA0000_010AAAAA_AAAAAAAA_AAAAAAAA, 16'h0000, 16'h0800, 16'h0400, 1, 5'd10, 2'd0, 0, 16'd2);
    x[2] = mk(128'hAAAAAAAA_AA000001_2BAAAAAA_AAAAAAAA, 16'h0000, 16'h0100, 16'h0080, 1, 5'd11, 2'd1, 0, 16'd3);
    x[3] = mk(128'hAAAAAAAA_AAAAAAAA_AAAA0000_016CAAAA, 16'h0000, 16'h0008, 16'h0004, 1, 5'd12, 2'd3, 0, 16'd4);
    oport_ready = 1'b0;
    iport = x[0].data; iflag = x[0].flag; iport_valid = 1'b1;
    step();
    chk_beat("bp x0", x[0]);
    iport = x[1].data; iflag = x[1].flag;
    for (int c = 0; c < 5; c++) begin
      s = $sformatf("bp stall%0d", c);
      chk({s, " iport_ready"}, {127'd0, iport_ready}, 128'd0);
      step();
      chk_beat(s, x[0]);
    end
    oport_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      iport = x[k].data; iflag = x[k].flag;
      step();
      chk_beat($sformatf("bp x%0d", k), x[k]);
    end
    iport_valid = 1'b0;
    step();
    chk("bp drain oport_valid", {127'd0, oport_valid}, 128'd0);
    chk("bp final nal_count", {112'd0, nal_count}, 128'd4);

    // Reset while a beat ending in 00 is stalled
    oport_ready = 1'b0;
    iport = 128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAA00; iflag = '0; iport_valid = 1'b1;
    step();
    iport_valid = 1'b0;
    step();
    chk("stall held oport_valid", {127'd0, oport_valid}, 128'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid-rst oport_valid", {127'd0, oport_valid}, 128'd0);
    chk("mid-rst oport", oport, 128'd0);
    chk("mid-rst nal_count", {112'd0, nal_count}, 128'd0);
    chk("mid-rst nal_unit_type", {123'd0, nal_unit_type}, 128'd0);
    chk("mid-rst nal_ref_idc", {126'd0, nal_ref_idc}, 128'd0);
    chk("mid-rst iport_ready", {127'd0, iport_ready}, 128'd1);
    oport_ready = 1'b1;
    y = mk(128'h0001AAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0000, 16'h0000, 16'h0000, 0, 5'd0, 2'd0, 0, 16'd0);
    iport = y.data; iflag = y.flag; iport_valid = 1'b1;
    step();
    chk_beat("post-rst 0001", y);
    y = mk(128'h000001E5_AAAAAAAA_AAAAAAAA_AAAAAAAA, 16'h0000, 16'h2000, 16'h1000, 1, 5'd5, 2'd3, 1, 16'd1);
    iport = y.data; iflag = y.flag;
    step();
    chk_beat("fzb E5", y);
    iport_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
